// File: rtl/opendap_cdc_req_src.sv
// Source side of a four-phase req/ack crossing: holds a word on data_o, raises req_o, waits for ack to return to zero.
// Optional ack timeout flag: define OPENDAP_CDC_SRC_TIMEOUT_EN.

module opendap_sync_1bit #(
    parameter int N_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [N_STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[N_STAGES-2:0], d};
        end
    end

    assign q = sync_q[N_STAGES-1];

endmodule

// state   | meaning
// IDLE    | no transfer; accepts a word once the synchronised ack is low
// REQ     | req_o high, data_o held, waiting for ack
// RELEASE | req_o low, data_o held, waiting for ack to return to zero
module opendap_cdc_req_src #(
    parameter int W         = 32,
    parameter int N_STAGES  = 2,
    parameter int TIMEOUT_W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         src_valid,
    output logic         src_ready,
    input  logic [W-1:0] src_data,
    output logic         done,
    output logic         req_o,
    output logic [W-1:0] data_o,
    input  logic         ack_i,
    output logic         busy,
    output logic         err,
    input  logic         err_clr
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   ack_sync;
    logic   accept;
    logic   done_d;

    opendap_sync_1bit #(
        .N_STAGES(N_STAGES)
    ) u_ack_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (ack_i),
        .q    (ack_sync)
    );

    // A stale ack left over from a previous transfer or reset blocks new requests.
    assign src_ready = (state_q == IDLE) && !ack_sync;
    assign busy      = (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (src_valid && src_ready) begin
                    state_d = REQ;
                    accept  = 1'b1;
                end
            end
            REQ: begin
                if (ack_sync) begin
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                if (!ack_sync) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            req_o   <= 1'b0;
            data_o  <= '0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            req_o   <= (state_d == REQ);
            done    <= done_d;
            if (accept) begin
                data_o <= src_data;
            end
        end
    end

`ifdef OPENDAP_CDC_SRC_TIMEOUT_EN
    localparam logic [TIMEOUT_W-1:0] CNT_MAX = '1;

    logic [TIMEOUT_W-1:0] cnt_q;
    logic                 entering;
    logic                 hit_max;

    assign entering = (state_d != state_q) && (state_d != IDLE);
    // Fires only on the step into all-ones so a cleared err stays clear while saturated.
    assign hit_max  = busy && !entering && (cnt_q == CNT_MAX - 1'b1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (entering) begin
            cnt_q <= '0;
        end else if (busy && (cnt_q != CNT_MAX)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (hit_max) begin
            err <= 1'b1;
        end else if (err_clr) begin
            err <= 1'b0;
        end
    end
`else
    logic unused_err_clr;

    assign err            = 1'b0;
    assign unused_err_clr = err_clr ^ TIMEOUT_W[0];
`endif

endmodule

// File: tb/tb_opendap_cdc_req_src.sv
// Directed bench for opendap_cdc_req_src (W=8, N_STAGES=2, TIMEOUT_W=4); inputs driven and outputs sampled 1ns after posedge.

module tb_opendap_cdc_req_src;

    logic       clk;
    logic       rst_n;
    logic       src_valid;
    logic       src_ready;
    logic [7:0] src_data;
    logic       done;
    logic       req_o;
    logic [7:0] data_o;
    logic       ack_i;
    logic       busy;
    logic       err;
    logic       err_clr;

    int total = 0;
    int bad   = 0;

    opendap_cdc_req_src #(
        .W        (8),
        .N_STAGES (2),
        .TIMEOUT_W(4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .src_valid(src_valid),
        .src_ready(src_ready),
        .src_data (src_data),
        .done     (done),
        .req_o    (req_o),
        .data_o   (data_o),
        .ack_i    (ack_i),
        .busy     (busy),
        .err      (err),
        .err_clr  (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Acts as a destination that echoes req_o one cycle later; returns when done is seen or the budget runs out.
    task automatic drain(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            ack_i = req_o;
            tick();
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        ack_i = 1'b0;
        tick();
        tick();
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        src_valid = 1'b0;
        src_data  = 8'h00;
        ack_i     = 1'b0;
        err_clr   = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        src_valid = 1'b0;
        src_data  = 8'h00;
        ack_i     = 1'b0;
        err_clr   = 1'b0;
        #1;
        total++;
        if ({req_o, data_o, done, busy, err, src_ready} !== {1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL reset_state: got req=%b data=%h done=%b busy=%b err=%b rdy=%b, want req=0 data=00 done=0 busy=0 err=0 rdy=1",
                     req_o, data_o, done, busy, err, src_ready);
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        src_valid = 1'b1;
        src_data  = 8'hA5;
        total++;
        if (src_ready !== 1'b1) begin
            bad++;
            $display("FAIL basic_ready_idle: got %b want 1", src_ready);
        end
        tick();
        src_valid = 1'b0;
        total++;
        if ({req_o, data_o, busy} !== {1'b1, 8'hA5, 1'b1}) begin
            bad++;
            $display("FAIL basic_accept: got req=%b data=%h busy=%b want req=1 data=a5 busy=1", req_o, data_o, busy);
        end
        tick();
        tick();
        tick();
        ack_i = 1'b1;
        // ack needs two synchroniser edges, then one FSM edge, before req_o drops
        for (int k = 1; k <= 3; k++) begin
            tick();
            total++;
            if (req_o !== (k < 3)) begin
                bad++;
                $display("FAIL basic_req_fall_k%0d: got req=%b want %b", k, req_o, (k < 3));
            end
        end
        tick();
        tick();
        tick();
        ack_i = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            total++;
            if ({done, src_ready, busy} !== {(k == 3), (k >= 3), (k < 3)}) begin
                bad++;
                $display("FAIL basic_done_k%0d: got done=%b rdy=%b busy=%b want done=%b rdy=%b busy=%b",
                         k, done, src_ready, busy, (k == 3), (k >= 3), (k < 3));
            end
            total++;
            if (data_o !== 8'hA5) begin
                bad++;
                $display("FAIL basic_data_hold_k%0d: got %h want a5", k, data_o);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] words [3];
        logic [7:0] cur;
        int         idx;
        int         ndone;
        bit         acc;
        words[0]  = 8'h01;
        words[1]  = 8'h02;
        words[2]  = 8'h03;
        idx       = 0;
        ndone     = 0;
        cur       = data_o;
        src_valid = 1'b1;
        src_data  = words[0];
        for (int cyc = 0; cyc < 80 && ndone < 3; cyc++) begin
            acc   = src_ready && src_valid;
            ack_i = req_o;
            tick();
            if (acc) begin
                total++;
                if (data_o !== words[idx]) begin
                    bad++;
                    $display("FAIL b2b_accept_%0d: got %h want %h", idx, data_o, words[idx]);
                end
                cur = words[idx];
                idx++;
                if (idx < 3) src_data = words[idx];
                else src_valid = 1'b0;
            end else if (busy) begin
                total++;
                if (data_o !== cur) begin
                    bad++;
                    $display("FAIL b2b_hold: got %h want %h", data_o, cur);
                end
            end
            if (done) ndone++;
            total++;
            if (done && busy) begin
                bad++;
                $display("FAIL b2b_done_busy: got done=1 busy=1 want not both");
            end
        end
        ack_i = 1'b0;
        total++;
        if (ndone !== 3 || idx !== 3) begin
            bad++;
            $display("FAIL b2b_count: got done=%0d accepted=%0d want 3 and 3", ndone, idx);
        end
        tick();
        tick();
    endtask

    task automatic test_stale_ack();
        bit ok;
        rst_n     = 1'b0;
        src_valid = 1'b0;
        src_data  = 8'h5A;
        ack_i     = 1'b1;
        tick();
        rst_n = 1'b1;
        // the synchroniser resets to 0, so let the stale ack propagate before offering a word
        tick();
        tick();
        src_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            total++;
            if ({src_ready, req_o} !== 2'b00) begin
                bad++;
                $display("FAIL stale_blocked_%0d: got rdy=%b req=%b want 0 0", k, src_ready, req_o);
            end
        end
        ack_i = 1'b0;
        tick();
        total++;
        if ({src_ready, req_o} !== 2'b00) begin
            bad++;
            $display("FAIL stale_edge1: got rdy=%b req=%b want 0 0", src_ready, req_o);
        end
        tick();
        total++;
        if ({src_ready, req_o} !== 2'b10) begin
            bad++;
            $display("FAIL stale_edge2: got rdy=%b req=%b want 1 0", src_ready, req_o);
        end
        tick();
        src_valid = 1'b0;
        total++;
        if ({req_o, data_o} !== {1'b1, 8'h5A}) begin
            bad++;
            $display("FAIL stale_accept: got req=%b data=%h want 1 5a", req_o, data_o);
        end
        drain(40, ok);
        total++;
        if (ok !== 1'b1) begin
            bad++;
            $display("FAIL stale_drain: got no done within 40 cycles, want done");
        end
    endtask

    task automatic test_reset_mid_req();
        src_valid = 1'b1;
        src_data  = 8'h3C;
        tick();
        src_valid = 1'b0;
        tick();
        total++;
        if ({req_o, data_o, busy} !== {1'b1, 8'h3C, 1'b1}) begin
            bad++;
            $display("FAIL midreq_setup: got req=%b data=%h busy=%b want 1 3c 1", req_o, data_o, busy);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({req_o, data_o, busy, done} !== {1'b0, 8'h00, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL midreq_async: got req=%b data=%h busy=%b done=%b want 0 00 0 0", req_o, data_o, busy, done);
        end
        tick();
        rst_n = 1'b1;
        tick();
        total++;
        if ({busy, src_ready, req_o} !== 3'b010) begin
            bad++;
            $display("FAIL midreq_after: got busy=%b rdy=%b req=%b want 0 1 0", busy, src_ready, req_o);
        end
    endtask

    task automatic test_data_hold();
        int  cyc;
        bit  seen;
        src_valid = 1'b1;
        src_data  = 8'h77;
        tick();
        seen = 1'b0;
        for (cyc = 0; cyc < 30; cyc++) begin
            src_data = ~src_data ^ 8'(cyc);
            total++;
            if (data_o !== 8'h77) begin
                bad++;
                $display("FAIL hold_cycle_%0d: got %h want 77", cyc, data_o);
            end
            if (done) begin
                seen = 1'b1;
                break;
            end
            ack_i = req_o;
            tick();
        end
        src_valid = 1'b0;
        ack_i     = 1'b0;
        total++;
        if (seen !== 1'b1) begin
            bad++;
            $display("FAIL hold_done: got no done within 30 cycles, want done");
        end
        // src_ready was high on the done cycle, so one more word may go out; let it finish
        tick();
        if (busy) begin
            bit ok;
            drain(40, ok);
        end
        tick();
        tick();
    endtask

    task automatic test_timeout();
        bit ok;
        src_valid = 1'b1;
        src_data  = 8'hC3;
        tick();
        src_valid = 1'b0;
`ifdef OPENDAP_CDC_SRC_TIMEOUT_EN
        for (int k = 1; k <= 16; k++) begin
            tick();
            total++;
            if ({err, req_o} !== {(k >= 15), 1'b1}) begin
                bad++;
                $display("FAIL timeout_k%0d: got err=%b req=%b want err=%b req=1", k, err, req_o, (k >= 15));
            end
        end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        total++;
        if ({err, req_o} !== 2'b01) begin
            bad++;
            $display("FAIL timeout_clr: got err=%b req=%b want 0 1", err, req_o);
        end
        tick();
        total++;
        if (err !== 1'b0) begin
            bad++;
            $display("FAIL timeout_clr_stays: got err=%b want 0", err);
        end
`else
        err_clr = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            total++;
            if ({err, req_o} !== 2'b01) begin
                bad++;
                $display("FAIL noerr_k%0d: got err=%b req=%b want 0 1", k, err, req_o);
            end
        end
        err_clr = 1'b0;
`endif
        drain(40, ok);
        total++;
        if (ok !== 1'b1) begin
            bad++;
            $display("FAIL timeout_drain: got no done within 40 cycles, want done");
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_stale_ack();
        test_reset_mid_req();
        do_reset();
        test_data_hold();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
